// File: rtl/prop_meas_pkg.sv
// Shared types and defaults for the propagation-delay measurement block.
package prop_meas_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } meas_state_e;

    // Result record at the default counter width.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] count;
        logic                 timeout;
        logic                 rise;
    } meas_res_t;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes one asynchronous bit and flags every transition of the
// synchronized level with a one-cycle pulse.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic async_in,
    output logic level,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchronizer chain followed by the previous-value flop for edge detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign level = sync_r[SYNC_STAGES-1];
    assign pulse = sync_r[SYNC_STAGES-1] ^ prev_r;

endmodule

// File: rtl/prop_delay_meter.sv
// Measures the number of clk cycles between a stimulus edge on start_i and
// the resulting edge on stop_i, with a timeout for outputs that never move.
// Both inputs see the same synchronizer latency, so it cancels in the count.
module prop_delay_meter
    import prop_meas_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             arm_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             busy_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [CNT_W-1:0] res_count_o,
    output logic             res_timeout_o,
    output logic             res_rise_o
);

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic             timeout;
        logic             rise;
    } res_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    meas_state_e      state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
    res_t             res_r, res_s;
    logic             valid_r;
    logic             start_lvl_s, start_e_s;
    logic             stop_lvl_s, stop_e_s;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_start_det (
        .clk      (clk),
        .nrst     (nrst),
        .async_in (start_i),
        .level    (start_lvl_s),
        .pulse    (start_e_s)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_stop_det (
        .clk      (clk),
        .nrst     (nrst),
        .async_in (stop_i),
        .level    (stop_lvl_s),
        .pulse    (stop_e_s)
    );

    assign cnt_inc_s = cnt_r + CNT_ONE;

    // Next-state, counter and result-capture logic of the measurement FSM.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        res_s   = res_r;
        case (state_r)
            IDLE: begin
                if (arm_i) begin
                    state_s = ARMED;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            ARMED: begin
                // A lone stop edge here is residue of the previous stimulus.
                if (start_e_s) begin
                    cnt_s      = CNT_ZERO;
                    res_s.rise = start_lvl_s;
                    if (stop_e_s) begin
                        state_s       = DONE;
                        res_s.count   = CNT_ZERO;
                        res_s.timeout = 1'b0;
                    end else begin
                        state_s = COUNT;
                    end
                end else begin
                    state_s = ARMED;
                end
            end
            COUNT: begin
                cnt_s = cnt_inc_s;
                // Stop takes priority over a timeout landing on the same cycle.
                if (stop_e_s) begin
                    state_s       = DONE;
                    res_s.count   = cnt_inc_s;
                    res_s.timeout = 1'b0;
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    state_s       = DONE;
                    res_s.count   = TIMEOUT_C;
                    res_s.timeout = 1'b1;
                end else begin
                    state_s = COUNT;
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counter, result and valid registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            res_r   <= '{count: CNT_ZERO, timeout: 1'b0, rise: 1'b0};
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            res_r   <= res_s;
            valid_r <= (state_s == DONE);
        end
    end

    assign busy_o        = (state_r != IDLE);
    assign res_valid_o   = valid_r;
    assign res_count_o   = res_r.count;
    assign res_timeout_o = res_r.timeout;
    assign res_rise_o    = res_r.rise;

endmodule

// File: doc/prop_delay_meter.md
Name: prop_delay_meter

Overview:
- Synthesizable measurement end of the propagation-time characterization flow.
- A sequencer launches a stimulus edge into a cell under test; this block timestamps that launch edge and the resulting output edge in clk cycles.
- It returns the elapsed count through a valid/ready result port.
- It includes a timeout, so a stuck output never hangs the sweep.

Parameters:
- CNT_W, 16, width of the cycle counter and of the result count.
- TIMEOUT, 1000, cycles after the start edge before the measurement is declared failed (must be < 2**CNT_W).
- SYNC_STAGES, 2, synchronizer depth applied to start_i and stop_i (minimum 2).

Ports:
- clk  input  1  Single clock; all state is on its rising edge.
- nrst  input  1  Reset, asynchronous, active-low.
- arm_i  input  1  One-cycle request to start a measurement. Accepted only in IDLE.
- start_i  input  1  Asynchronous stimulus (DUT input) observation.
- stop_i  input  1  Asynchronous DUT output observation.
- busy_o  output  1  High in ARMED, COUNT and DONE.
- res_valid_o  output  1  Result available.
- res_ready_i  input  1  Consumer accepts the result.
- res_count_o  output  CNT_W  Cycles from the start-edge detection to the stop-edge detection.
- res_timeout_o  output  1  Result is a timeout, not a measurement.
- res_rise_o  output  1  1 if the start edge was rising, 0 if falling.

Behaviour:
- Reset (nrst=0, asynchronous):
  - State is IDLE.
  - Synchronizer flops and previous-value flops are cleared to 0.
  - busy_o, res_valid_o, res_timeout_o and res_rise_o are 0; res_count_o is 0.
  - Reset asserted mid-measurement aborts the measurement; no result is produced.
- Input conditioning:
  - start_i and stop_i each pass through SYNC_STAGES flops, then one edge-detect flop.
  - An edge is any transition of the synchronized value (start_e, stop_e).
  - Both paths have identical delay, so the latency cancels in the count.
- States:
  - IDLE: arm_i=1 -> ARMED, counter cleared. Edges are ignored.
  - ARMED:
    - On start_e, capture res_rise_o = new synchronized start value and clear the counter.
    - If stop_e occurs in the same cycle -> DONE with count 0.
    - Otherwise -> COUNT.
    - stop_e without start_e is ignored; it is treated as leftover from the previous stimulus.
    - No timeout in ARMED.
  - COUNT:
    - The counter increments each cycle.
    - On stop_e, latch count = cycles since the start detection (stop detected 1 cycle after start gives 1) -> DONE, timeout=0.
    - If the counter reaches TIMEOUT without stop_e -> DONE with res_count_o=TIMEOUT, res_timeout_o=1.
    - Further start_e is ignored.
    - If stop_e and the TIMEOUT condition coincide, stop wins (timeout=0, count=TIMEOUT).
  - DONE:
    - res_valid_o=1.
    - res_count_o, res_timeout_o and res_rise_o are held stable until the handshake.
    - When res_valid_o and res_ready_i are both 1 -> IDLE; res_valid_o drops the next cycle.
    - arm_i in DONE, including the handshake cycle, is ignored; a new arm is needed from IDLE.
- Result outputs stay at their last values in IDLE; they are meaningful only while res_valid_o=1.
- Counter width: CNT_W bits, never wraps (bounded by TIMEOUT).
- busy_o is combinational from state.

Decomposition:
- Shared package prop_meas_pkg:
  - State enum (IDLE, ARMED, COUNT, DONE).
  - Default CNT_W and TIMEOUT constants.
  - Result struct {count, timeout, rise}.
- One sub-module, sync_edge_det (parameter SYNC_STAGES):
  - Synchronizes one asynchronous bit.
  - Outputs the synchronized level and a one-cycle edge pulse.
  - Instantiated twice.

Test Plan:
- Reset/idle: hold nrst=0 for 3 cycles, toggle start_i/stop_i -> all outputs 0, busy_o=0. After release, edges without arm_i leave state IDLE.
- Basic rise: arm, raise start_i, lower stop_i exactly 5 cycles later (both held stable) -> res_valid_o=1, res_count_o=5, res_rise_o=1, res_timeout_o=0.
- Fall, back-pressure: arm, fall start_i, stop 12 cycles later, hold res_ready_i=0 for 10 cycles -> outputs stable at count 12, rise=0. One cycle after ready=1, valid=0 and busy=0.
- Timeout: TIMEOUT=20, arm, start edge, no stop edge -> after 20 counting cycles valid=1, timeout=1, count=20.
- Same-cycle and spurious edges:
  - Stop edge before start is ignored.
  - Start and stop toggled in the same clk cycle -> count=0.
  - Second start edge during COUNT does not restart the count.
- Abort: assert nrst in COUNT at cycle 7 -> immediate idle with all outputs 0. The next armed measurement of 3 cycles reports count 3.
